// File: rtl/jump_sequencer.sv
// jump_sequencer: tick-paced jump-arc controller for the obstacle game.
// A rising edge of the jump button launches the arc. On each step
// (a tick while not frozen) the height climbs by STEP up to MAX_HEIGHT,
// holds at the apex for HOLD_TICKS steps, then descends by STEP to ground.
// A cooldown of COOLDOWN_TICKS steps follows each landing. One press made
// during the fall or the cooldown is buffered and relaunches from IDLE.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   tick       in   one-cycle frame pulse; motion advances only on tick
//   jump_btn   in   synchronized jump button level
//   freeze     in   pause/collision; holds all sequencing state while high
//   height     out  [W-1:0] current height above ground
//   busy       out  sequencer is not idle
//   airborne   out  height is non-zero
//   apex       out  sequencer is holding at the apex
//   landed     out  one-cycle pulse on the clock where height returns to 0
//   jump_count out  [7:0] completed jumps, saturating at 255
//
// The hold and cooldown counters are 8 bits wide, so HOLD_TICKS and
// COOLDOWN_TICKS must not exceed 255.
module jump_sequencer #(
  parameter int W              = 10,
  parameter int STEP           = 10,
  parameter int MAX_HEIGHT     = 100,
  parameter int HOLD_TICKS     = 3,
  parameter int COOLDOWN_TICKS = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         jump_btn,
  input  logic         freeze,
  output logic [W-1:0] height,
  output logic         busy,
  output logic         airborne,
  output logic         apex,
  output logic         landed,
  output logic [7:0]   jump_count
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RISE     = 3'd1,
    HOLD     = 3'd2,
    FALL     = 3'd3,
    COOLDOWN = 3'd4
  } state_t;

  // Arithmetic runs one bit wider than height so the rise sum cannot wrap.
  localparam logic [W:0]   STEP_X    = (W+1)'(STEP);
  localparam logic [W:0]   MAX_X     = (W+1)'(MAX_HEIGHT);
  localparam logic [W-1:0] MAX_H     = W'(MAX_HEIGHT);
  localparam logic [W-1:0] STEP_H    = W'(STEP);
  localparam logic [7:0]   HOLD_INIT = 8'(HOLD_TICKS);
  localparam logic [7:0]   CD_INIT   = 8'(COOLDOWN_TICKS);

  state_t       state_r, state_n;
  logic [W-1:0] height_r, height_n;
  logic [7:0]   hold_cnt_r, hold_n;
  logic [7:0]   cd_cnt_r, cd_n;
  logic         pending_r, pending_n;
  logic         btn_prev_r;
  logic         landed_r, landed_n;
  logic [7:0]   jump_count_r, count_n;

  logic         btn_rise_s;
  logic         step_s;
  logic [W:0]   rise_sum_s;

  assign btn_rise_s = jump_btn & ~btn_prev_r & ~freeze;
  assign step_s     = tick & ~freeze;
  assign rise_sum_s = {1'b0, height_r} + STEP_X;

  // State and datapath registers, including the button edge history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      height_r     <= {W{1'b0}};
      hold_cnt_r   <= 8'd0;
      cd_cnt_r     <= 8'd0;
      pending_r    <= 1'b0;
      btn_prev_r   <= 1'b0;
      landed_r     <= 1'b0;
      jump_count_r <= 8'd0;
    end else begin
      state_r      <= state_n;
      height_r     <= height_n;
      hold_cnt_r   <= hold_n;
      cd_cnt_r     <= cd_n;
      pending_r    <= pending_n;
      btn_prev_r   <= jump_btn;
      landed_r     <= landed_n;
      jump_count_r <= count_n;
    end
  end

  // Next-state and datapath update; freeze leaves everything as it is.
  always_comb begin
    state_n   = state_r;
    height_n  = height_r;
    hold_n    = hold_cnt_r;
    cd_n      = cd_cnt_r;
    pending_n = pending_r;
    landed_n  = 1'b0;
    count_n   = jump_count_r;
    if (!freeze) begin
      case (state_r)
        IDLE: begin
          // Launch only changes state; a coincident tick moves nothing.
          if (btn_rise_s || pending_r) begin
            state_n   = RISE;
            pending_n = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end
        RISE: begin
          if (step_s) begin
            if (rise_sum_s >= MAX_X) begin
              height_n = MAX_H;
              state_n  = HOLD;
              hold_n   = HOLD_INIT;
            end else begin
              height_n = rise_sum_s[W-1:0];
            end
          end else begin
            height_n = height_r;
          end
        end
        HOLD: begin
          if (step_s) begin
            if (hold_cnt_r <= 8'd1) begin
              state_n = FALL;
            end else begin
              hold_n = hold_cnt_r - 8'd1;
            end
          end else begin
            hold_n = hold_cnt_r;
          end
        end
        FALL: begin
          if (btn_rise_s) begin
            pending_n = 1'b1;
          end else begin
            pending_n = pending_r;
          end
          if (step_s) begin
            if ({1'b0, height_r} <= STEP_X) begin
              height_n = {W{1'b0}};
              landed_n = 1'b1;
              if (jump_count_r != 8'd255) begin
                count_n = jump_count_r + 8'd1;
              end else begin
                count_n = jump_count_r;
              end
              if (COOLDOWN_TICKS == 0) begin
                state_n = IDLE;
              end else begin
                state_n = COOLDOWN;
                cd_n    = CD_INIT;
              end
            end else begin
              height_n = height_r - STEP_H;
            end
          end else begin
            height_n = height_r;
          end
        end
        COOLDOWN: begin
          if (btn_rise_s) begin
            pending_n = 1'b1;
          end else begin
            pending_n = pending_r;
          end
          if (step_s) begin
            if (cd_cnt_r <= 8'd1) begin
              state_n = IDLE;
            end else begin
              cd_n = cd_cnt_r - 8'd1;
            end
          end else begin
            cd_n = cd_cnt_r;
          end
        end
        default: begin
          state_n  = IDLE;
          height_n = {W{1'b0}};
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  assign height     = height_r;
  assign busy       = (state_r != IDLE);
  assign airborne   = (height_r != {W{1'b0}});
  assign apex       = (state_r == HOLD);
  assign landed     = landed_r;
  assign jump_count = jump_count_r;

endmodule

// File: doc/jump_sequencer.md
Name: jump_sequencer

Overview:
Tick-paced controller that sequences the player's jump arc for the obstacle game. It edge-detects the jump button and steps player height up to a ceiling, holds at the apex, then steps height back down. A cooldown follows before the next jump, and one early press is buffered. Sits between the input synchronizer and the VGA sprite/collision logic; `height` is the vertical offset added to the player sprite's ground row.

Parameters:
W, 10, width of height bus
STEP, 10, height change per tick during rise/fall
MAX_HEIGHT, 100, apex height; rise clamps here
HOLD_TICKS, 3, ticks spent at apex (0 = fall on the tick after apex reached)
COOLDOWN_TICKS, 4, ticks after landing before a new jump may start (0 = none)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
tick  in  1  one-cycle frame-rate pulse; all motion advances only on tick
jump_btn  in  1  synchronized jump button level
freeze  in  1  game paused/collision; stalls all sequencing while high
height  out  W  current jump height above ground
busy  out  1  state != IDLE
airborne  out  1  height != 0
apex  out  1  state == HOLD
landed  out  1  one-cycle pulse on the clk where height returns to 0
jump_count  out  8  completed jumps, saturates at 255

Behaviour:
- Reset (reset==0, async): state=IDLE, height=0, landed=0, jump_count=0, pending=0, btn_prev=0, hold/cooldown counters=0. All outputs are registered or decoded from state/height, so they read 0 during reset.
- btn_prev <= jump_btn every clk. btn_rise = jump_btn & ~btn_prev & ~freeze. Holding the button does not retrigger.
- States: IDLE, RISE, HOLD, FALL, COOLDOWN. "Step" below means tick & ~freeze. With freeze high, the state, height, counters and pending are all held.
- IDLE:
  - On btn_rise or pending: go to RISE on the next clk and clear pending.
  - Height is not changed on this transition. A tick in the same cycle is not consumed for height.
- RISE, on step:
  - If height + STEP >= MAX_HEIGHT: height=MAX_HEIGHT, go to HOLD, hold_cnt=HOLD_TICKS.
  - Otherwise height += STEP.
  - Compute the sum at W+1 bits so it cannot wrap.
- HOLD, on step:
  - If hold_cnt <= 1: go to FALL.
  - Otherwise hold_cnt -= 1.
- FALL, on step:
  - If height <= STEP: height=0, landed=1 for that clk, jump_count += 1 (saturating).
  - On landing, go to COOLDOWN with cd_cnt=COOLDOWN_TICKS; if COOLDOWN_TICKS==0, go straight to IDLE.
  - Otherwise height -= STEP. Height never underflows.
- COOLDOWN, on step:
  - If cd_cnt <= 1: go to IDLE.
  - Otherwise cd_cnt -= 1.
- Jump buffer:
  - btn_rise in FALL or COOLDOWN sets pending (one deep; further presses are absorbed).
  - btn_rise in RISE or HOLD is ignored.
  - pending launches from IDLE with no new press.
- landed is 0 on every clk other than the landing clk.
- Reset mid-jump returns height to 0 immediately. No landed pulse and no count increment.
- Latency, default parameters:
  - The press edge reaches RISE 1 clk after the button rises.
  - 10 rise ticks, 3 hold ticks, 10 fall ticks, 4 cooldown ticks.

Test Plan:
- Basic arc, defaults:
  - Stimulus: release reset; pulse jump_btn 1 cycle; tick every 4 clks.
  - Response: height 10,20,…,100 on ticks 1–10; apex=1 for 3 ticks; height 90…0 on fall ticks 1–10.
  - landed high exactly 1 clk; jump_count=1; busy drops 4 ticks after landing.
- Held button:
  - Stimulus: jump_btn high for 200 ticks.
  - Response: exactly one jump; jump_count=1 after cooldown; state stays IDLE afterwards.
- Buffered jump:
  - Stimulus: second press while height=40 in FALL.
  - Response: pending set; after the 4 cooldown ticks, RISE starts with no further press; jump_count reaches 2.
- Press ignored during rise:
  - Stimulus: press at height=30 in RISE.
  - Response: no pending; a single jump only.
- Freeze:
  - Stimulus: assert freeze at height=60 in RISE for 20 ticks, with a press meanwhile.
  - Response: height stays 60, no pending. After release, the rise resumes 70…100.
- Clamp and reset:
  - Stimulus: STEP=30, MAX_HEIGHT=100.
  - Response: height 30,60,90,100 then fall 70,40,10,0.
  - Stimulus: drive reset=0 at height 70.
  - Response: height=0 asynchronously; landed=0; jump_count unchanged at 0.
